// File: rtl/la_pkg.sv
// rtl/la_pkg.sv - shared logic analyzer capture types and sizing constants
package la_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CAPT,
    DONE
  } capt_state_t;

  localparam int ENTRIES_DEF = 384;
  localparam int LOG2_DEF    = 9;

endpackage

// File: rtl/wrap_addr_cnt.sv
// rtl/wrap_addr_cnt.sv - address counter with enable, sync clear and wrap at ENTRIES-1
module wrap_addr_cnt #(
  parameter int ENTRIES = 384,
  parameter int LOG2    = 9
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clr,
  input  logic            en,
  output logic [LOG2-1:0] cnt
);

  localparam logic [LOG2-1:0] LAST = LOG2'(ENTRIES - 1);

  // Clear has priority over advance; the last entry rolls back to zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= (cnt == LAST) ? '0 : cnt + LOG2'(1);
    end
  end

endmodule

// File: rtl/capture_ctrl.sv
// rtl/capture_ctrl.sv - capture RAM write sequencer; CAPT_PRETRIG_FILL_EN gates trigger until pre-trigger fill
module capture_ctrl
  import la_pkg::*;
#(
  parameter int ENTRIES = ENTRIES_DEF,
  parameter int LOG2    = LOG2_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            wrt_smpl,
  input  logic            run,
  input  logic            capture_done,
  input  logic            triggered,
  input  logic [LOG2-1:0] trig_pos,
  output logic            we,
  output logic [LOG2-1:0] waddr,
  output logic [LOG2-1:0] ram_addr,
  output logic            armed,
  output logic            set_capture_done
);

  localparam logic [LOG2-1:0] LAST = LOG2'(ENTRIES - 1);

  capt_state_t     state;
  logic [LOG2-1:0] trig_cnt;
  logic            trig_lat;
  logic [LOG2-1:0] tp_eff;
  logic            in_capt;
  logic            complete;
  logic            start;

  // A post-trigger count beyond the RAM depth is meaningless; clamp it
  assign tp_eff   = (trig_pos > LAST) ? LAST : trig_pos;
  assign in_capt  = (state == CAPT);
  assign start    = (state == IDLE) && run && !capture_done;
  // Completion uses registered counts, and suppresses any write in that cycle
  assign complete = in_capt && trig_lat && (trig_cnt == tp_eff);
  assign we       = in_capt && wrt_smpl && !complete;

  wrap_addr_cnt #(
    .ENTRIES (ENTRIES),
    .LOG2    (LOG2)
  ) u_waddr (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (start),
    .en    (we),
    .cnt   (waddr)
  );

`ifdef CAPT_PRETRIG_FILL_EN
  localparam logic [LOG2:0] FULL = (LOG2 + 1)'(ENTRIES);

  logic [LOG2:0] smpl_cnt;
  logic [LOG2:0] smpl_nxt;
  logic [LOG2:0] arm_thr;
  logic          armed_q;

  assign smpl_nxt = (smpl_cnt == FULL) ? FULL : smpl_cnt + (LOG2 + 1)'(1);
  assign arm_thr  = FULL - {1'b0, tp_eff};
  assign armed    = armed_q;

  // Pre-trigger fill tracking: arm once enough history precedes the trigger window
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      smpl_cnt <= '0;
      armed_q  <= 1'b0;
    end else if (!in_capt || !run) begin
      smpl_cnt <= '0;
      armed_q  <= 1'b0;
    end else if (we) begin
      smpl_cnt <= smpl_nxt;
      if (smpl_nxt >= arm_thr) begin
        armed_q <= 1'b1;
      end
    end
  end
`else
  assign armed = in_capt;
`endif

  // Capture sequencer: start, trigger latch, post-trigger count, completion, abort
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= IDLE;
      ram_addr         <= '0;
      set_capture_done <= 1'b0;
      trig_cnt         <= '0;
      trig_lat         <= 1'b0;
    end else begin
      set_capture_done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            trig_cnt <= '0;
            trig_lat <= 1'b0;
            state    <= CAPT;
          end
        end
        CAPT: begin
          if (!run) begin
            state <= IDLE;
          end else if (complete) begin
            set_capture_done <= 1'b1;
            ram_addr         <= (waddr == '0) ? LAST : waddr - LOG2'(1);
            state            <= DONE;
          end else begin
            if (armed && triggered) begin
              trig_lat <= 1'b1;
            end
            if (we && trig_lat) begin
              trig_cnt <= trig_cnt + LOG2'(1);
            end
          end
        end
        DONE: begin
          if (!capture_done) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
